reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port register file for the MIPS datapath, replacing the fixed 2R/1W file.
//  Provides NUM_RD asynchronous read ports, NUM_WR clocked write ports, a hardwired-zero register 0,
//  and a busy-bit scoreboard so issue logic can stall reads of pending destinations.
//  Sits between decode (read/alloc) and write-back (write ports).
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   register address width; depth = 2**ADDR_W
//  NUM_RD  2   number of read ports
//  NUM_WR  2   number of write ports; higher index has priority
// PORTS
//  clk         in   1              rising-edge clock
//  reset_n     in   1              asynchronous, active-low reset
//  rd_addr     in   NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rd_data     out  NUM_RD*DATA_W  packed read data, combinational
//  rd_ready    out  NUM_RD         1 = operand valid (register not busy)
//  wr_en       in   NUM_WR         per-port write enable
//  wr_addr     in   NUM_WR*ADDR_W  packed write addresses
//  wr_data     in   NUM_WR*DATA_W  packed write data
//  alloc_en    in   1              mark alloc_addr busy (instruction issued with this destination)
//  alloc_addr  in   ADDR_W         destination being allocated
//  alloc_ok    out  1              combinational: allocation accepted this cycle
// BEHAVIOUR
//  - Reset (reset_n=0, async): all registers = 0, all busy bits = 0, immediately; rd_data = 0, rd_ready = all 1.
//  - Writes: on posedge clk, wr_en[j] && wr_addr_j != 0 -> reg[wr_addr_j] <= wr_data_j. Same address on
//    several ports: highest j wins. Writes to address 0 are dropped.
//  - Reads: rd_data_i = reg[rd_addr_i], zero latency; address 0 always reads 0.
//  - Scoreboard: busy[a] is set at posedge when alloc_en && alloc_ok && alloc_addr == a && a != 0.
//    busy[a] is cleared at posedge by any enabled write to a.
//  - Simultaneous alloc and write to the same address: data is written, busy ends 1 (the new producer wins).
//  - alloc_ok = !alloc_en || alloc_addr == 0 || !busy[alloc_addr]. A rejected alloc changes nothing (WAW stall).
//  - rd_ready_i = (rd_addr_i == 0) || !busy[rd_addr_i].
//  - Reset asserted mid-operation aborts all pending busy bits; writes in that cycle are lost.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read port whose address matches an enabled write this cycle returns that
//    wr_data (highest j wins) and rd_ready_i = 1. Address 0 is never bypassed.
//  REGFILE_BYPASS_EN undefined: reads return the pre-edge stored value. rd_ready follows busy only.
// STRUCTURE
//  - Package regfile_pkg: DATA_W/ADDR_W defaults, ZERO_REG = 0, a function that unpacks a port slice.
//  - Sub-module reg_scoreboard: busy vector, alloc/clear logic, alloc_ok, per-port ready.
//  - Top level: storage array, write-priority loop, read muxes, bypass generate block.
// TESTING
//  1. Reset: write 0xDEADBEEF to r5 and assert reset_n=0 mid-cycle -> rd_data(r5)=0 at once; rd_ready all 1.
//  2. Write priority: wr0 r3=0x11111111 and wr1 r3=0x22222222 in the same cycle -> r3 reads 0x22222222.
//  3. Zero reg: write 0x12470000 to r0 -> rd_data(r0)=0 and rd_ready=1. Alloc r0 -> alloc_ok=1, busy unchanged.
//  4. Scoreboard: alloc r13, next cycle -> rd_ready(r13)=0. Alloc r13 again -> alloc_ok=0.
//     Write r13=0x12470000 -> rd_ready=1 next cycle and the data reads back.
//  5. Alloc+write same cycle on r7 -> r7 holds the write data and busy[r7]=1 after the edge.
//  6. Bypass: read r9 while writing r9=0xCAFEF00D -> 0xCAFEF00D with REGFILE_BYPASS_EN, old value without it.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file (reg_file_mp).
// Optional feature macro used by the top: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    // Packed port buses are widened to MAX_VEC_W before slicing; a single field is at most SLICE_W bits.
    localparam int MAX_VEC_W  = 1024;
    localparam int SLICE_W    = 64;

    function automatic logic [SLICE_W-1:0] port_slice(
        input logic [MAX_VEC_W-1:0] vec,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [SLICE_W-1:0] mask;
        mask = (w >= SLICE_W) ? {SLICE_W{1'b1}} : ((SLICE_W'(1) << w) - SLICE_W'(1));
        return SLICE_W'(vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between decode/write-back and the multi-port register file.
// busy_dbg exposes the scoreboard state so checkers can observe it directly.
interface reg_file_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]         rd_ready;
    logic [NUM_WR-1:0]         wr_en;
    logic [NUM_WR*ADDR_W-1:0]  wr_addr;
    logic [NUM_WR*DATA_W-1:0]  wr_data;
    logic                      alloc_en;
    logic [ADDR_W-1:0]         alloc_addr;
    logic                      alloc_ok;
    logic [(1<<ADDR_W)-1:0]    busy_dbg;

    // Allocation handshake: alloc_en is valid, alloc_ok is ready, and an allocation takes effect
    // only at a rising edge where both are high. alloc_ok drops only for a busy nonzero target;
    // nothing is remembered about a refused request, so the master retries until accepted.
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_ready, alloc_ok, busy_dbg
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_ready, alloc_ok, busy_dbg
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Busy-bit scoreboard for reg_file_mp: tracks pending destinations, gates new
// allocations (WAW stall) and reports per-read-port operand readiness.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int NUM_RD = 2,
    localparam int DEPTH  = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic [DEPTH-1:0]         clr_mask,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic                     alloc_ok,
    output logic [NUM_RD-1:0]        rd_ready,
    output logic [DEPTH-1:0]         busy
);
    logic [DEPTH-1:0] busy_nxt;
    logic             alloc_nonzero;

    assign alloc_nonzero = (alloc_addr != ADDR_W'(ZERO_REG));
    assign alloc_ok      = !alloc_en || !alloc_nonzero || !busy[alloc_addr];

    // Set after clear: a write retiring the old producer and a new allocation leave the register busy.
    always_comb begin
        busy_nxt = busy & ~clr_mask;
        if (alloc_en && alloc_ok && alloc_nonzero) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rd_ready = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_ready[i] = (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_REG)) ||
                          !busy[rd_addr[i*ADDR_W +: ADDR_W]];
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with hardwired-zero r0 and busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs      [DEPTH];
    logic [ADDR_W-1:0] rd_addr_a [NUM_RD];
    logic [ADDR_W-1:0] wr_addr_a [NUM_WR];
    logic [DATA_W-1:0] wr_data_a [NUM_WR];
    logic [DEPTH-1:0]  clr_mask;
    logic [NUM_RD-1:0] sb_ready;

    // Port fields are limited to SLICE_W bits and each packed bus to MAX_VEC_W bits.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr_a[i] = ADDR_W'(port_slice(MAX_VEC_W'(bus.rd_addr), unsigned'(i), unsigned'(ADDR_W)));
        end
        for (int j = 0; j < NUM_WR; j++) begin
            wr_addr_a[j] = ADDR_W'(port_slice(MAX_VEC_W'(bus.wr_addr), unsigned'(j), unsigned'(ADDR_W)));
            wr_data_a[j] = DATA_W'(port_slice(MAX_VEC_W'(bus.wr_data), unsigned'(j), unsigned'(DATA_W)));
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && wr_addr_a[j] != ADDR_W'(ZERO_REG)) begin
                clr_mask[wr_addr_a[j]] = 1'b1;
            end
        end
    end

    // Ascending loop: the last assignment to an address belongs to the highest port and wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && wr_addr_a[j] != ADDR_W'(ZERO_REG)) begin
                    regs[wr_addr_a[j]] <= wr_data_a[j];
                end
            end
        end
    end

    always_comb begin
        bus.rd_data  = '0;
        bus.rd_ready = sb_ready;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_addr_a[i] != ADDR_W'(ZERO_REG)) begin
                bus.rd_data[i*DATA_W +: DATA_W] = regs[rd_addr_a[i]];
            end
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && wr_addr_a[j] == rd_addr_a[i] &&
                    rd_addr_a[i] != ADDR_W'(ZERO_REG)) begin
                    bus.rd_data[i*DATA_W +: DATA_W] = wr_data_a[j];
                    bus.rd_ready[i]                 = 1'b1;
                end
            end
`endif
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .clr_mask   (clr_mask),
        .rd_addr    (bus.rd_addr),
        .alloc_ok   (bus.alloc_ok),
        .rd_ready   (sb_ready),
        .busy       (bus.busy_dbg)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against an array-based model of the register file.
module tb_reg_file_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- model & counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mdl_regs [DEPTH];
    logic          mdl_busy [DEPTH];
    logic          mdl_ok;
    int            mdl_aa;
    int            mdl_wa;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                mdl_regs[a] = '0;
                mdl_busy[a] = 1'b0;
            end
        end else begin
            mdl_aa = int'(bus.alloc_addr);
            mdl_ok = !bus.alloc_en || mdl_aa == 0 || !mdl_busy[mdl_aa];
            for (int j = 0; j < NW; j++) begin
                mdl_wa = int'(bus.wr_addr[j*AW +: AW]);
                if (bus.wr_en[j] && mdl_wa != 0) begin
                    mdl_regs[mdl_wa] = bus.wr_data[j*DW +: DW];
                    mdl_busy[mdl_wa] = 1'b0;
                end
            end
            if (bus.alloc_en && mdl_ok && mdl_aa != 0) mdl_busy[mdl_aa] = 1'b1;
        end
    end

    function automatic int rd_a(int p);
        return int'(bus.rd_addr[p*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] exp_data(int p);
        int a = rd_a(p);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = mdl_regs[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == a) v = bus.wr_data[j*DW +: DW];
`endif
        return v;
    endfunction

    function automatic logic exp_ready(int p);
        int a = rd_a(p);
        logic r;
        if (a == 0) return 1'b1;
        r = !mdl_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == a) r = 1'b1;
`endif
        return r;
    endfunction

    function automatic logic [DW-1:0] mdl_busy_vec();
        logic [DW-1:0] v = '0;
        for (int a = 0; a < DEPTH; a++) v[a] = mdl_busy[a];
        return v;
    endfunction

    task automatic cmp(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got 0x%08h want 0x%08h", name, idx, $time, act, exp);
        end
    endtask

    task automatic check_lit(string name, logic [DW-1:0] act);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no expectation queued, got 0x%08h want none", name, act);
        end else begin
            cmp(name, 0, act, exp_q.pop_front());
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int p = 0; p < NR; p++) begin
            cmp("rd_data", p, bus.rd_data[p*DW +: DW], exp_data(p));
            cmp("rd_ready", p, DW'(bus.rd_ready[p]), DW'(exp_ready(p)));
        end
        cmp("alloc_ok", 0, DW'(bus.alloc_ok),
            DW'(!bus.alloc_en || bus.alloc_addr == '0 || !mdl_busy[int'(bus.alloc_addr)]));
        cmp("busy", 0, bus.busy_dbg, mdl_busy_vec());
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.alloc_en   = 1'b0;
        bus.alloc_addr = '0;
    endtask

    task automatic set_rd(int p, int a);
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(int p, int a, logic [DW-1:0] d);
        bus.wr_en[p]            = 1'b1;
        bus.wr_addr[p*AW +: AW] = AW'(a);
        bus.wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_alloc(int a);
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = AW'(a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd_port(int p);
        return bus.rd_data[p*DW +: DW];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        idle();
        bus.rd_addr = '0;
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();

        // reset mid-cycle wipes stored data at once
        set_wr(0, 5, 32'hDEADBEEF);
        set_rd(0, 5);
        step();
        idle();
        #2;
        exp_q.push_back(32'hDEADBEEF); check_lit("r5_written", rd_port(0));
        reset_n = 1'b0;
        #1;
        exp_q.push_back(32'h0);        check_lit("r5_after_reset", rd_port(0));
        exp_q.push_back(32'h3);        check_lit("ready_in_reset", DW'(bus.rd_ready));
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();

        // write priority: port 1 beats port 0
        set_wr(0, 3, 32'h11111111);
        set_wr(1, 3, 32'h22222222);
        step();
        idle();
        set_rd(0, 3);
        #2;
        exp_q.push_back(32'h22222222); check_lit("wr_priority", rd_port(0));
        step();

        // zero register
        set_wr(0, 0, 32'h12470000);
        set_alloc(0);
        set_rd(0, 0);
        #2;
        exp_q.push_back(32'h1);        check_lit("alloc_r0_ok", DW'(bus.alloc_ok));
        exp_q.push_back(32'h0);        check_lit("r0_data", rd_port(0));
        exp_q.push_back(32'h1);        check_lit("r0_ready", DW'(bus.rd_ready[0]));
        step();
        idle();
        #2;
        exp_q.push_back(32'h0);        check_lit("busy_after_r0", bus.busy_dbg);
        step();

        // scoreboard on r13
        set_alloc(13);
        #2;
        exp_q.push_back(32'h1);        check_lit("alloc_r13_ok", DW'(bus.alloc_ok));
        step();
        idle();
        set_alloc(13);
        set_rd(1, 13);
        #2;
        exp_q.push_back(32'h0);        check_lit("r13_not_ready", DW'(bus.rd_ready[1]));
        exp_q.push_back(32'h0);        check_lit("alloc_r13_waw", DW'(bus.alloc_ok));
        step();
        idle();
        set_wr(0, 13, 32'h12470000);
        step();
        idle();
        #2;
        exp_q.push_back(32'h1);        check_lit("r13_ready", DW'(bus.rd_ready[1]));
        exp_q.push_back(32'h12470000); check_lit("r13_data", rd_port(1));
        step();

        // alloc and write same cycle: data lands, register stays busy
        set_alloc(7);
        set_wr(1, 7, 32'hA5A50007);
        set_rd(0, 7);
        step();
        idle();
        #2;
        exp_q.push_back(32'h1);        check_lit("r7_busy", DW'(bus.busy_dbg[7]));
        exp_q.push_back(32'h0);        check_lit("r7_not_ready", DW'(bus.rd_ready[0]));
        exp_q.push_back(32'hA5A50007); check_lit("r7_data", rd_port(0));
        step();

        // same-cycle read of a register being written
        set_wr(0, 9, 32'h0BAD0009);
        step();
        idle();
        set_wr(0, 9, 32'hCAFEF00D);
        set_rd(0, 9);
        #2;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'hCAFEF00D);
`else
        exp_q.push_back(32'h0BAD0009);
`endif
        check_lit("r9_same_cycle", rd_port(0));
        exp_q.push_back(32'h1);        check_lit("r9_ready", DW'(bus.rd_ready[0]));
        step();
        idle();
        #2;
        exp_q.push_back(32'hCAFEF00D); check_lit("r9_after", rd_port(0));

        // randomized traffic on a narrow address range to force collisions
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int p = 0; p < NR; p++) set_rd(p, $urandom_range(0, 15));
            for (int j = 0; j < NW; j++) begin
                bus.wr_en[j]            = ($urandom_range(0, 2) == 0);
                bus.wr_addr[j*AW +: AW] = AW'($urandom_range(0, 15));
                bus.wr_data[j*DW +: DW] = $urandom;
            end
            bus.alloc_en   = ($urandom_range(0, 1) == 0);
            bus.alloc_addr = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset_n = 1'b0;
                @(posedge clk);
                #2 reset_n = 1'b1;
            end
        end
        step();
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
